// File: rtl/fpalu_pkg.sv
// Shared constants and types for the 29-bit "uni" floating-point ALU.
// Rounding mode is selected by the FPALU_RNE_EN macro (see fpalu_norm).
package fpalu_pkg;

  localparam int EXP_W  = 6;
  localparam int MAN_W  = 22;
  localparam int BIAS   = 31;

  // Aligned add mantissa: MAN_W bits plus guard, round, sticky
  localparam int EXT_W  = MAN_W + 3;
  localparam int NORM_W = 2 * MAN_W;
  localparam int LZ_W   = 6;
  // Signed working exponent wide enough for ea+eb-BIAS-lz
  localparam int XEXP_W = 10;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_uni_t;

  localparam fp_uni_t FP_ZERO = '{sgn: 1'b0, exp: '0, man: '0};

  function automatic fp_uni_t fp_sat(input logic sgn);
    fp_sat = '{sgn: sgn, exp: '1, man: '1};
  endfunction

endpackage

// File: rtl/fpalu_norm.sv
// Combinational leading-zero count, left normalize and exponent adjust.
// With FPALU_RNE_EN defined it also reports the round-to-nearest-even increment.
module fpalu_norm
  import fpalu_pkg::*;
(
  input  logic [NORM_W-1:0]        man_in,
  input  logic signed [XEXP_W-1:0] exp_in,
  output logic [MAN_W-1:0]         man_out,
  output logic signed [XEXP_W-1:0] exp_out,
  output logic                     round_up,
  output logic                     zero_out
);

  logic [LZ_W-1:0] lz;
  logic            found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = NORM_W - 1; i >= 0; i--) begin
      if (!found && man_in[i]) begin
        lz    = LZ_W'(NORM_W - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign zero_out = ~|man_in;
  assign exp_out  = exp_in - $signed({{(XEXP_W-LZ_W){1'b0}}, lz});

`ifdef FPALU_RNE_EN
  logic [NORM_W-1:0] shifted;
  assign shifted  = man_in << lz;
  assign man_out  = shifted[NORM_W-1 -: MAN_W];
  // guard & (round | sticky | lsb): ties go to even
  assign round_up = shifted[NORM_W-MAN_W-1]
                  & (shifted[NORM_W-MAN_W-2] | (|shifted[NORM_W-MAN_W-3:0])
                     | shifted[NORM_W-MAN_W]);
`else
  assign man_out  = MAN_W'((man_in << lz) >> (NORM_W - MAN_W));
  assign round_up = 1'b0;
`endif

endmodule

// File: rtl/fp_alu.sv
// Two-stage pipelined adder/multiplier for the 29-bit uni FP format.
// Define FPALU_RNE_EN for round-to-nearest-even; default truncates.
module fp_alu
  import fpalu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_uni_a_sgn,
  input  logic [EXP_W-1:0] din_uni_a_exp,
  input  logic [MAN_W-1:0] din_uni_a_man_dn,
  input  logic             din_uni_b_sgn,
  input  logic [EXP_W-1:0] din_uni_b_exp,
  input  logic [MAN_W-1:0] din_uni_b_man_dn,
  input  logic             add_muln,
  output logic             dout_uni_y_sgn,
  output logic [EXP_W-1:0] dout_uni_y_exp,
  output logic [MAN_W-1:0] dout_uni_y_man_dn
);

  // ---------------- stage 1: align/add or multiply ----------------
  logic                     a_zero, b_zero, a_big;
  logic                     big_sgn, small_sgn;
  logic [EXP_W-1:0]         big_exp, small_exp, ediff;
  logic [MAN_W-1:0]         big_man, small_man;
  logic [EXT_W-1:0]         big_ext, small_ext;
  logic [EXT_W+MAN_W+1:0]   wide;
  logic [EXT_W:0]           sum_mag;
  logic                     add_sgn;
  logic [NORM_W-1:0]        prod;

  logic                     s1_sgn_reg,  s1_sgn_next;
  logic signed [XEXP_W-1:0] s1_exp_reg,  s1_exp_next;
  logic [NORM_W-1:0]        s1_man_reg,  s1_man_next;

  assign a_zero = ~|din_uni_a_man_dn;
  assign b_zero = ~|din_uni_b_man_dn;
  // A zero operand never wins alignment, so x + 0 returns x
  assign a_big  = b_zero | (~a_zero & (din_uni_a_exp >= din_uni_b_exp));

  assign big_sgn   = a_big ? din_uni_a_sgn    : din_uni_b_sgn;
  assign big_exp   = a_big ? din_uni_a_exp    : din_uni_b_exp;
  assign big_man   = a_big ? din_uni_a_man_dn : din_uni_b_man_dn;
  assign small_sgn = a_big ? din_uni_b_sgn    : din_uni_a_sgn;
  assign small_exp = a_big ? din_uni_b_exp    : din_uni_a_exp;
  assign small_man = a_big ? din_uni_b_man_dn : din_uni_a_man_dn;
  assign ediff     = big_exp - small_exp;

  assign big_ext = {big_man, 3'b000};
  assign wide    = {small_man, 3'b000, {(MAN_W+2){1'b0}}} >> ediff;
  // Bits shifted past the round position collapse into the sticky bit
  assign small_ext = (ediff >= EXP_W'(24)) ? '0
                   : {wide[EXT_W+MAN_W+1 -: EXT_W-1], |wide[MAN_W+2:0]};

  always_comb begin
    sum_mag = '0;
    add_sgn = big_sgn;
    if (big_sgn == small_sgn) begin
      sum_mag = {1'b0, big_ext} + {1'b0, small_ext};
    end else if (big_ext >= small_ext) begin
      sum_mag = {1'b0, big_ext} - {1'b0, small_ext};
    end else begin
      sum_mag = {1'b0, small_ext} - {1'b0, big_ext};
      add_sgn = small_sgn;
    end
  end

  assign prod = din_uni_a_man_dn * din_uni_b_man_dn;

  always_comb begin
    s1_sgn_next = din_uni_a_sgn ^ din_uni_b_sgn;
    s1_exp_next = $signed({{(XEXP_W-EXP_W){1'b0}}, din_uni_a_exp})
                + $signed({{(XEXP_W-EXP_W){1'b0}}, din_uni_b_exp})
                - $signed(XEXP_W'(BIAS));
    s1_man_next = prod;
    if (add_muln) begin
      // Carry position sits one above the larger exponent
      s1_sgn_next = add_sgn;
      s1_exp_next = $signed({{(XEXP_W-EXP_W){1'b0}}, big_exp}) + $signed(XEXP_W'(1));
      s1_man_next = {sum_mag, {(NORM_W-EXT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sgn_reg <= 1'b0;
      s1_exp_reg <= '0;
      s1_man_reg <= '0;
    end else begin
      s1_sgn_reg <= s1_sgn_next;
      s1_exp_reg <= s1_exp_next;
      s1_man_reg <= s1_man_next;
    end
  end

  // ---------------- stage 2: normalize, round, pack ----------------
  logic [MAN_W-1:0]         norm_man;
  logic signed [XEXP_W-1:0] norm_exp;
  logic                     norm_round_up, norm_zero;
  logic [MAN_W:0]           man_inc;
  logic [MAN_W-1:0]         man_fin;
  logic signed [XEXP_W-1:0] exp_fin;
  fp_uni_t                  y_reg, y_next;

  fpalu_norm u_norm (
    .man_in   (s1_man_reg),
    .exp_in   (s1_exp_reg),
    .man_out  (norm_man),
    .exp_out  (norm_exp),
    .round_up (norm_round_up),
    .zero_out (norm_zero)
  );

  always_comb begin
    man_inc = {1'b0, norm_man} + {{MAN_W{1'b0}}, norm_round_up};
    man_fin = man_inc[MAN_W-1:0];
    exp_fin = norm_exp;
    if (man_inc[MAN_W]) begin
      man_fin = {1'b1, {(MAN_W-1){1'b0}}};
      exp_fin = norm_exp + $signed(XEXP_W'(1));
    end

    y_next = '{sgn: s1_sgn_reg, exp: exp_fin[EXP_W-1:0], man: man_fin};
    if (norm_zero || exp_fin < $signed(XEXP_W'(0))) begin
      y_next = FP_ZERO;
    end else if (exp_fin > $signed(XEXP_W'((1 << EXP_W) - 1))) begin
      y_next = fp_sat(s1_sgn_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg <= FP_ZERO;
    end else begin
      y_reg <= y_next;
    end
  end

  assign dout_uni_y_sgn    = y_reg.sgn;
  assign dout_uni_y_exp    = y_reg.exp;
  assign dout_uni_y_man_dn = y_reg.man;

endmodule

// File: tb/tb_fp_alu.sv
// Directed self-checking bench for fp_alu; expectations follow FPALU_RNE_EN.
module tb_fp_alu;

  localparam int N = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_sgn, b_sgn, add_muln;
  logic [5:0]  a_exp, b_exp;
  logic [21:0] a_man, b_man;
  logic        y_sgn;
  logic [5:0]  y_exp;
  logic [21:0] y_man;
  logic [28:0] y_obs;

  int checks = 0;
  int failures = 0;

  logic [28:0] va [N];
  logic [28:0] vb [N];
  logic [28:0] vy [N];
  logic        vm [N];

  always #5 clk = ~clk;

  fp_alu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .din_uni_a_sgn     (a_sgn),
    .din_uni_a_exp     (a_exp),
    .din_uni_a_man_dn  (a_man),
    .din_uni_b_sgn     (b_sgn),
    .din_uni_b_exp     (b_exp),
    .din_uni_b_man_dn  (b_man),
    .add_muln          (add_muln),
    .dout_uni_y_sgn    (y_sgn),
    .dout_uni_y_exp    (y_exp),
    .dout_uni_y_man_dn (y_man)
  );

  assign y_obs = {y_sgn, y_exp, y_man};

  function automatic logic [28:0] fp(input logic s, input logic [5:0] e, input logic [21:0] m);
    fp = {s, e, m};
  endfunction

  task automatic check_eq(input string tag, input logic [28:0] got, input logic [28:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got={%0d,%0d,%06h} want={%0d,%0d,%06h}", tag,
               got[28], got[27:22], got[21:0], exp_v[28], exp_v[27:22], exp_v[21:0]);
    end else begin
      $display("ok   %s y={%0d,%0d,%06h}", tag, got[28], got[27:22], got[21:0]);
    end
  endtask

  task automatic drive(input logic [28:0] a, input logic [28:0] b, input logic m);
    {a_sgn, a_exp, a_man} = a;
    {b_sgn, b_exp, b_man} = b;
    add_muln = m;
  endtask

  initial begin
    // value = man/2^22 * 2^(exp-31); 1.0 = {0,32,200000}
    va[0]  = fp(0,32,22'h200000); vb[0]  = fp(0,32,22'h200000); vm[0]  = 1; vy[0]  = fp(0,33,22'h200000);
    va[1]  = fp(0,32,22'h200000); vb[1]  = fp(1,32,22'h200000); vm[1]  = 1; vy[1]  = fp(0,0,22'h000000);
    va[2]  = fp(0,34,22'h080000); vb[2]  = fp(0,32,22'h200000); vm[2]  = 1; vy[2]  = fp(0,33,22'h200000);
    va[3]  = fp(0,32,22'h200000); vb[3]  = fp(0,32,22'h300000); vm[3]  = 0; vy[3]  = fp(0,32,22'h300000);
    va[4]  = fp(1,32,22'h200000); vb[4]  = fp(0,32,22'h300000); vm[4]  = 0; vy[4]  = fp(1,32,22'h300000);
    va[5]  = fp(0,32,22'h000000); vb[5]  = fp(1,40,22'h300000); vm[5]  = 0; vy[5]  = fp(0,0,22'h000000);
    va[6]  = fp(0,63,22'h3FFFFF); vb[6]  = fp(0,63,22'h3FFFFF); vm[6]  = 0; vy[6]  = fp(0,63,22'h3FFFFF);
    va[7]  = fp(0,1,22'h200000);  vb[7]  = fp(0,1,22'h200000);  vm[7]  = 0; vy[7]  = fp(0,0,22'h000000);
    va[8]  = fp(0,32,22'h200000); vb[8]  = fp(1,30,22'h200000); vm[8]  = 1; vy[8]  = fp(0,31,22'h300000);
    va[9]  = fp(1,32,22'h200000); vb[9]  = fp(0,30,22'h200000); vm[9]  = 1; vy[9]  = fp(1,31,22'h300000);
    va[10] = fp(0,32,22'h300000); vb[10] = fp(0,32,22'h300000); vm[10] = 0; vy[10] = fp(0,33,22'h240000);
    va[11] = fp(0,63,22'h200000); vb[11] = fp(0,63,22'h200000); vm[11] = 1; vy[11] = fp(0,63,22'h3FFFFF);
    va[12] = fp(0,16,22'h200000); vb[12] = fp(0,16,22'h200000); vm[12] = 0; vy[12] = fp(0,0,22'h200000);
    va[13] = fp(0,32,22'h200000); vb[13] = fp(0,8,22'h3FFFFF);  vm[13] = 1; vy[13] = fp(0,32,22'h200000);
    va[14] = fp(0,32,22'h200000); vb[14] = fp(0,10,22'h3FFFFF); vm[14] = 1;
`ifdef FPALU_RNE_EN
    vy[14] = fp(0,32,22'h200001);
`else
    vy[14] = fp(0,32,22'h200000);
`endif
    va[15] = fp(0,50,22'h000000); vb[15] = fp(0,32,22'h300000); vm[15] = 1; vy[15] = fp(0,32,22'h300000);
    va[16] = fp(1,63,22'h3FFFFF); vb[16] = fp(0,63,22'h3FFFFF); vm[16] = 0; vy[16] = fp(1,63,22'h3FFFFF);

    drive(fp(0,32,22'h200000), fp(0,32,22'h200000), 1'b1);
    repeat (3) @(posedge clk);
    #1 check_eq("reset_state", y_obs, 29'd0);
    rst_n = 1'b1;

    // Back-to-back stream: the result for vector i-1 is visible after edge i+1
    for (int i = 0; i <= N; i++) begin
      if (i < N) drive(va[i], vb[i], vm[i]);
      else       drive(29'd0, 29'd0, 1'b1);
      @(posedge clk);
      #1;
      if (i >= 1) check_eq($sformatf("vec%0d_%s", i - 1, vm[i-1] ? "add" : "mul"), y_obs, vy[i-1]);
    end

    drive(va[0], vb[0], 1'b1);
    repeat (2) @(posedge clk);
    #1 check_eq("pre_reset_add", y_obs, vy[0]);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset_now", y_obs, 29'd0);
    @(posedge clk);
    #1 check_eq("reset_held", y_obs, 29'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("flushed_after_reset", y_obs, 29'd0);
    @(posedge clk);
    #1 check_eq("refill_after_reset", y_obs, vy[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
